// File: rtl/loader_pkg.sv
// loader_pkg: shared types and helpers for the serial program loader.
package loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_FAIL} state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-flop synchroniser, mid-bit sampling and glitch rejection.
module uart_rx_core #(
  parameter int CPB = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frm_err
);
  localparam int CW = $clog2(CPB);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
  rstate_t st, st_nx;
  logic rx_m, rx_s, rx_q, tick, half;
  logic [CW-1:0] tmr;
  logic [2:0] idx;
  assign tick = tmr == CW'(CPB - 1);
  assign half = tmr == CW'(CPB / 2 - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= R_IDLE;
    else st <= st_nx;
  always_comb begin
    st_nx = st;
    case (st)
      R_IDLE:  st_nx = rx_q && !rx_s ? R_START : R_IDLE;
      R_START: st_nx = !half ? R_START : rx_s ? R_IDLE : R_DATA;
      R_DATA:  st_nx = tick && idx == 3'd7 ? R_STOP : R_DATA;
      default: st_nx = tick ? R_IDLE : R_STOP;
    endcase
  end
  // rx_q holds the previous synchronised level so only a true falling edge starts a frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {rx_m, rx_s, rx_q} <= 3'b111;
      tmr <= '0;
      idx <= '0;
      data <= '0;
      byte_valid <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      {rx_m, rx_s, rx_q} <= {rx, rx_m, rx_s};
      tmr <= st_nx != st || tick ? '0 : tmr + 1'b1;
      if (st == R_START) idx <= '0;
      if (st == R_DATA && tick) begin
        data <= {rx_s, data[7:1]};
        idx <= idx + 1'b1;
      end
      byte_valid <= st == R_STOP && tick && rx_s;
      frm_err <= st == R_STOP && tick && !rx_s;
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: UART program loader writing CPU RAM and driving CPU halt/restart.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte per frame.
module prog_loader
  import loader_pkg::*;
#(
  parameter int         CLK_FREQ  = 1400000,
  parameter int         BAUD      = 9600,
  parameter int         ADDR_W    = 4,
  parameter int         DATA_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_halt,
  output logic              cpu_restart,
  output logic              load_done,
  output logic              load_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  state_t state, state_nx;
  logic [7:0] rx_data, sum;
  logic rx_valid, rx_err, last, len_bad;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0] len;
  uart_rx_core #(.CPB(clks_per_bit(CLK_FREQ, BAUD))) u_rx (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(rx_data), .byte_valid(rx_valid), .frm_err(rx_err)
  );
  assign last = {1'b0, cnt} == len - 1'b1;
  assign len_bad = rx_data == 8'd0 || int'(rx_data) > DEPTH;
  assign cpu_restart = state == S_DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = rx_valid && rx_data == SYNC_BYTE ? S_LEN : S_IDLE;
      S_LEN:  state_nx = rx_err ? S_FAIL : !rx_valid ? S_LEN : len_bad ? S_FAIL : S_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_DATA: state_nx = rx_err ? S_FAIL : rx_valid && last ? S_CHK : S_DATA;
      S_CHK:  state_nx = rx_err ? S_FAIL : !rx_valid ? S_CHK : rx_data == sum ? S_DONE : S_FAIL;
`else
      S_DATA: state_nx = rx_err ? S_FAIL : rx_valid && last ? S_DONE : S_DATA;
`endif
      default: state_nx = S_IDLE;
    endcase
  end
  // cpu_halt is only released from S_DONE, so every RAM write happens while halted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      cpu_halt <= 1'b0;
      load_done <= 1'b0;
      load_err <= 1'b0;
      cnt <= '0;
      len <= '0;
      sum <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        S_IDLE: if (state_nx == S_LEN) begin
          cpu_halt <= 1'b1;
          load_done <= 1'b0;
          load_err <= 1'b0;
        end
        S_LEN: begin
          cnt <= '0;
          sum <= '0;
          len <= rx_data[ADDR_W:0];
        end
        S_DATA: if (rx_valid) begin
          ram_we <= 1'b1;
          ram_addr <= cnt;
          ram_wdata <= DATA_W'(rx_data);
          sum <= sum + rx_data;
          cnt <= cnt + 1'b1;
        end
        S_DONE: begin
          cpu_halt <= 1'b0;
          load_done <= 1'b1;
        end
        S_FAIL: load_err <= 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and randomized frames checked against a frame-level reference model.
module tb_prog_loader;
  localparam int CPB = 10;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic ram_we, cpu_halt, cpu_restart, load_done, load_err;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  int checks = 0, errors = 0, restarts = 0, bytes_seen = 0, e_restarts = 0;
  bit e_done, e_err, e_halt;
  logic [11:0] got_w[$], exp_w[$];

  prog_loader #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .cpu_halt(cpu_halt), .cpu_restart(cpu_restart),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      got_w.push_back({ram_addr, ram_wdata});
      checks++;
      if (cpu_halt !== 1'b1) begin
        errors++;
        $display("FAIL halt_on_write: cpu_halt=%b required 1", cpu_halt);
      end
    end
    if (cpu_restart === 1'b1) restarts++;
    if (dut.u_rx.byte_valid === 1'b1) bytes_seen++;
  end

  // Frame-level reference: parses the byte stream as the loader protocol describes it
  task automatic model(input logic [7:0] b[$], input bit ok[$]);
    int i, len;
    logic [7:0] sum;
    bit fail;
    i = 0;
    while (i < b.size()) begin
      if (!(ok[i] && b[i] == 8'hA5)) begin
        i++;
        continue;
      end
      e_halt = 1; e_done = 0; e_err = 0;
      i++;
      if (i >= b.size()) return;
      if (!ok[i] || b[i] == 0 || b[i] > 16) begin
        e_err = 1;
        i++;
        continue;
      end
      len = b[i]; i++; sum = 0; fail = 0;
      for (int k = 0; k < len && !fail; k++) begin
        if (i >= b.size()) return;
        if (!ok[i]) fail = 1;
        else begin
          exp_w.push_back({4'(k), b[i]});
          sum += b[i];
        end
        i++;
      end
`ifdef LOADER_CHECKSUM_EN
      if (!fail) begin
        if (i >= b.size()) return;
        fail = !ok[i] || b[i] != sum;
        i++;
      end
`endif
      if (fail) e_err = 1;
      else begin
        e_done = 1; e_halt = 0; e_restarts++;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic play(input logic [7:0] b[$], input bit ok[$]);
    got_w.delete();
    exp_w.delete();
    model(b, ok);
    foreach (b[i]) send_byte(b[i], ok[i]);
    repeat (20) @(negedge clk);
  endtask

  task automatic play_vec(input logic [63:0] v, input int n, input int bad);
    logic [7:0] b[$];
    bit ok[$];
    for (int k = 0; k < n; k++) begin
      b.push_back(v[8*(n-1-k) +: 8]);
      ok.push_back(k != bad);
    end
    play(b, ok);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_we, ram_addr, ram_wdata, cpu_halt, cpu_restart, load_done, load_err} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {ram_we, ram_addr, ram_wdata, cpu_halt, cpu_restart, load_done, load_err});
    end
    rst_n = 1'b1;
    e_done = 0; e_err = 0; e_halt = 0;
    repeat (5) @(negedge clk);
    checks++;
    if ({cpu_halt, load_done, load_err, ram_we} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b required 0000", {cpu_halt, load_done, load_err, ram_we});
    end
  endtask

  task automatic test_good_frame();
    int r0;
    logic [23:0] wv;
    r0 = restarts;
    wv = 24'h112233;
`ifdef LOADER_CHECKSUM_EN
    play_vec(48'hA5_03_11_22_33_66, 6, -1);
`else
    play_vec(40'hA5_03_11_22_33, 5, -1);
`endif
    checks++;
    if (got_w.size() != 3) begin
      errors++;
      $display("FAIL good_nwrites: got %0d required 3", got_w.size());
    end else
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_w[k] !== {4'(k), wv[8*(2-k) +: 8]}) begin
          errors++;
          $display("FAIL good_write%0d: got %h required %h", k, got_w[k], {4'(k), wv[8*(2-k) +: 8]});
        end
      end
    checks++;
    if ({load_done, load_err, cpu_halt} !== 3'b100) begin
      errors++;
      $display("FAIL good_status: done/err/halt got %b required 100", {load_done, load_err, cpu_halt});
    end
    checks++;
    if (restarts - r0 != 1) begin
      errors++;
      $display("FAIL good_restart: got %0d pulses required 1", restarts - r0);
    end
  endtask

  task automatic test_ignored_and_glitch();
    int n0;
    n0 = bytes_seen;
    play_vec(24'h00FF5A, 3, -1);
    checks++;
    if (bytes_seen - n0 != 3) begin
      errors++;
      $display("FAIL ignored_bytes_rx: got %0d bytes required 3", bytes_seen - n0);
    end
    checks++;
    if (got_w.size() != 0 || {load_done, load_err, cpu_halt} !== 3'b100) begin
      errors++;
      $display("FAIL ignored_status: writes %0d done/err/halt %b required 0 100", got_w.size(), {load_done, load_err, cpu_halt});
    end
    n0 = bytes_seen;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (bytes_seen != n0) begin
      errors++;
      $display("FAIL glitch_no_byte: got %0d bytes required 0", bytes_seen - n0);
    end
    checks++;
    if (cpu_halt !== 1'b0) begin
      errors++;
      $display("FAIL glitch_halt: got %b required 0", cpu_halt);
    end
  endtask

  task automatic check_fail(input string name, input int nw, input int r0);
    checks++;
    if (got_w.size() != nw) begin
      errors++;
      $display("FAIL %s_nwrites: got %0d required %0d", name, got_w.size(), nw);
    end
    checks++;
    if ({load_done, load_err, cpu_halt} !== 3'b011) begin
      errors++;
      $display("FAIL %s_status: done/err/halt got %b required 011", name, {load_done, load_err, cpu_halt});
    end
    checks++;
    if (restarts != r0) begin
      errors++;
      $display("FAIL %s_restart: got %0d pulses required 0", name, restarts - r0);
    end
  endtask

  task automatic test_errors();
    int r0;
    r0 = restarts;
`ifdef LOADER_CHECKSUM_EN
    play_vec(48'hA5_03_11_22_33_67, 6, -1);
    check_fail("bad_chk", 3, r0);
`endif
    play_vec(16'hA5_00, 2, -1);
    check_fail("len_zero", 0, r0);
    play_vec(16'hA5_11, 2, -1);
    check_fail("len_big", 0, r0);
    play_vec(24'hA5_02_11, 3, 2);
    check_fail("framing", 0, r0);
  endtask

`ifndef LOADER_CHECKSUM_EN
  task automatic test_no_chk();
    int r0;
    r0 = restarts;
    play_vec(32'hA5_02_AA_BB, 4, -1);
    checks++;
    if (got_w.size() != 2 || got_w[0] !== 12'h0AA || got_w[1] !== 12'h1BB) begin
      errors++;
      $display("FAIL nochk_writes: got %0d writes required 0AA 1BB", got_w.size());
    end
    checks++;
    if ({load_done, load_err, cpu_halt} !== 3'b100 || restarts - r0 != 1) begin
      errors++;
      $display("FAIL nochk_status: done/err/halt %b pulses %0d required 100 1", {load_done, load_err, cpu_halt}, restarts - r0);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int r0;
    got_w.delete();
    send_byte(8'hA5, 1); send_byte(8'h05, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    repeat (5) @(negedge clk);
    checks++;
    if (cpu_halt !== 1'b1 || got_w.size() != 2) begin
      errors++;
      $display("FAIL mid_frame_busy: halt %b writes %0d required 1 2", cpu_halt, got_w.size());
    end
    rx = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_wdata, cpu_halt, cpu_restart, load_done, load_err} !== 17'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h required 0", {ram_we, ram_addr, ram_wdata, cpu_halt, cpu_restart, load_done, load_err});
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    e_done = 0; e_err = 0; e_halt = 0;
    repeat (5) @(negedge clk);
    r0 = restarts;
`ifdef LOADER_CHECKSUM_EN
    play_vec(40'hA5_02_40_41_81, 5, -1);
`else
    play_vec(32'hA5_02_40_41, 4, -1);
`endif
    checks++;
    if (got_w.size() != 2 || {load_done, load_err, cpu_halt} !== 3'b100 || restarts - r0 != 1) begin
      errors++;
      $display("FAIL reload_after_reset: writes %0d status %b pulses %0d required 2 100 1", got_w.size(), {load_done, load_err, cpu_halt}, restarts - r0);
    end
  endtask

  task automatic test_random();
    logic [7:0] b[$], g, sum;
    bit ok[$];
    int len, r0, e0, a5, p;
    for (int it = 0; it < 25; it++) begin
      b.delete(); ok.delete();
      repeat ($urandom_range(0, 2)) begin
        do g = 8'($urandom); while (g == 8'hA5);
        b.push_back(g);
      end
      a5 = b.size();
      b.push_back(8'hA5);
      len = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) ? 0 : int'($urandom_range(17, 255))) : int'($urandom_range(1, 16));
      b.push_back(8'(len));
      if (len >= 1 && len <= 16) begin
        sum = 0;
        for (int k = 0; k < len; k++) begin
          g = 8'($urandom);
          sum += g;
          b.push_back(g);
        end
`ifdef LOADER_CHECKSUM_EN
        b.push_back($urandom_range(0, 3) == 0 ? sum ^ 8'($urandom_range(1, 255)) : sum);
`endif
      end
      foreach (b[i]) ok.push_back(1'b1);
      if ($urandom_range(0, 5) == 0) begin
        p = $urandom_range(a5 + 1, b.size() - 1);
        ok[p] = 1'b0;
        while (b.size() > p + 1) begin
          void'(b.pop_back());
          void'(ok.pop_back());
        end
      end
      r0 = restarts;
      e0 = e_restarts;
      play(b, ok);
      checks++;
      if (got_w.size() != exp_w.size()) begin
        errors++;
        $display("FAIL rand%0d_nwrites: got %0d required %0d", it, got_w.size(), exp_w.size());
      end else
        foreach (exp_w[k]) begin
          checks++;
          if (got_w[k] !== exp_w[k]) begin
            errors++;
            $display("FAIL rand%0d_write%0d: got %h required %h", it, k, got_w[k], exp_w[k]);
          end
        end
      checks++;
      if ({load_done, load_err, cpu_halt} !== {e_done, e_err, e_halt}) begin
        errors++;
        $display("FAIL rand%0d_status: done/err/halt got %b required %b", it, {load_done, load_err, cpu_halt}, {e_done, e_err, e_halt});
      end
      checks++;
      if (restarts - r0 != e_restarts - e0) begin
        errors++;
        $display("FAIL rand%0d_restart: got %0d pulses required %0d", it, restarts - r0, e_restarts - e0);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_ignored_and_glitch();
    test_errors();
`ifndef LOADER_CHECKSUM_EN
    test_no_chk();
`endif
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
